neuron_accumulator: RTL and testbench
=====================================

// Module: neuron_accumulator
// PURPOSE
//   Downstream stage of the 16-input adder tree in each hidden/output neuron.
//   Accumulates BEATS consecutive 16-term partial sums plus a bias into one
//   neuron pre-activation (e.g. 64 inputs = 4 beats x 16), then hands the
//   DWIDTH-bit result to the sigmoid stage over a valid/ready handshake.
// PARAMETERS
//   DWIDTH  16  data width; two's-complement fixed point, same format as adder tree output
//   BEATS   4   partial sums per frame (IWIDTH/16); legal range 1..256
//   GUARD   4   accumulator guard bits; ACCW = DWIDTH+GUARD; must be >= clog2(BEATS+1)
// PORTS
//   clk        in   1       clock, rising edge
//   rst_n      in   1       asynchronous reset, active low
//   clr        in   1       synchronous frame abort
//   in_valid   in   1       in_data beat valid
//   in_ready   out  1       block accepts a beat this cycle
//   in_data    in   DWIDTH  signed partial sum from the adder tree
//   in_bias    in   DWIDTH  signed bias; sampled with the first beat of a frame
//   out_valid  out  1       result valid for the sigmoid stage
//   out_ready  in   1       sigmoid stage accepts the result
//   out_data   out  DWIDTH  signed neuron pre-activation
//   out_sat    out  1       result was saturated (ACC_SAT_EN only)
// BEHAVIOUR
//   - Reset (rst_n=0, any time): state=IDLE, beat_cnt=0, acc=0, out_valid=0,
//     out_data=0, out_sat=0; in_ready=1 once rst_n is released. A partial frame is discarded.
//   - Beat accepted when in_valid && in_ready. in_ready = !out_valid || out_ready.
//   - States: IDLE -> ACC on the first accepted beat (acc = sext(in_bias)+sext(in_data),
//     beat_cnt=1); ACC: each accepted beat adds sext(in_data) and increments beat_cnt;
//     the beat that makes beat_cnt==BEATS finishes the frame -> HOLD. BEATS=1:
//     IDLE -> HOLD directly, with acc = bias+data.
//   - HOLD: out_valid=1; out_data/out_sat stable until out_valid && out_ready.
//     Same-cycle pop plus new first beat is legal: result leaves and the next frame
//     starts in that cycle, so the block sustains one beat per clock with no bubble.
//   - Latency: out_valid rises on the clock edge that accepts the last beat
//     (visible the following cycle).
//   - Arithmetic: ACCW-bit signed accumulation, never wraps within legal GUARD.
//     Final reduction to DWIDTH is set by CONFIGURATION.
//   - clr (sync, highest priority after reset): returns to IDLE, beat_cnt=0,
//     drops out_valid; any beat presented in that cycle is ignored.
//   - in_valid low in mid-frame: state and count hold; no timeout.
//   - beat_cnt width clog2(BEATS+1); resets to 0 at frame end; no wrap within a frame.
// CONFIGURATION
//   ACC_SAT_EN defined: acc > 2^(DWIDTH-1)-1 -> out_data = max positive (0x7FFF),
//     acc < -2^(DWIDTH-1) -> out_data = most negative (0x8000), out_sat=1; otherwise
//     out_data = acc[DWIDTH-1:0] and out_sat=0.
//   ACC_SAT_EN undefined: out_data = acc[DWIDTH-1:0] (wrap, matches adder tree);
//     out_sat is tied to 0.
// TESTING (DWIDTH=16, BEATS=4, GUARD=4)
//   - Beats 0x0100,0x0200,0x0300,0x0400, bias 0x0010, out_ready=1 -> out_data=0x0A10,
//     out_sat=0; out_valid high for exactly 1 cycle after the 4th beat.
//   - 4 x 0x7000, bias 0 -> sum 0x1C000: with ACC_SAT_EN 0x7FFF, out_sat=1;
//     without ACC_SAT_EN 0xC000, out_sat=0.
//   - 4 x 0x9000, bias 0xF000 -> sum -118784: with ACC_SAT_EN 0x8000, out_sat=1.
//   - Hold out_ready=0 for 3 cycles after a result -> out_data stable, in_ready=0;
//     raise out_ready with the next first beat valid -> pop and accept in the same cycle.
//   - After 2 beats of 0x0100, pulse rst_n low (or clr high) -> out_valid=0; next frame
//     of 4 x 0x0001, bias 0 -> 0x0004 (no residue from the aborted frame).
//   - Back-to-back 3 frames with in_valid=1 and out_ready=1 throughout -> 3 results on
//     consecutive 4-cycle boundaries, no dropped or duplicated beats.

Source files
------------

// File: rtl/neuron_accumulator_if.sv
// rtl/neuron_accumulator_if.sv - partial-sum input and pre-activation output handshake bundle
interface neuron_accumulator_if #(
  parameter int DWIDTH = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DWIDTH-1:0] in_data;
  logic [DWIDTH-1:0] in_bias;
  logic              out_valid;
  logic              out_ready;
  logic [DWIDTH-1:0] out_data;
  logic              out_sat;

  // Adder-tree / sigmoid side: drives beats and the result-accept strobe
  modport master (
    output in_valid, in_data, in_bias, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  // Accumulator side
  modport slave (
    input  in_valid, in_data, in_bias, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/neuron_accumulator.sv
// rtl/neuron_accumulator.sv - sums BEATS partial sums plus bias per neuron; optional saturation via ACC_SAT_EN
module neuron_accumulator #(
  parameter int DWIDTH = 16,
  parameter int BEATS  = 4,
  parameter int GUARD  = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 clr_i,
  neuron_accumulator_if.slave  bus
);

  localparam int ACCW = DWIDTH + GUARD;
  localparam int CW   = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic signed [ACCW-1:0]  acc_q, acc_d;
  logic [DWIDTH-1:0]       data_q, data_d;
  logic                    valid, accept, pop;
  logic signed [ACCW-1:0]  bias_x, data_x;

`ifdef ACC_SAT_EN
  localparam logic signed [ACCW-1:0] MAX_V = ACCW'((2 ** (DWIDTH - 1)) - 1);
  localparam logic signed [ACCW-1:0] MIN_V = ~MAX_V;
  logic sat_q, sat_d;
`endif

  assign valid  = (state_q == HOLD);
  assign accept = bus.in_valid && bus.in_ready;
  assign pop    = valid && bus.out_ready;
  assign bias_x = {{GUARD{bus.in_bias[DWIDTH-1]}}, bus.in_bias};
  assign data_x = {{GUARD{bus.in_data[DWIDTH-1]}}, bus.in_data};

  assign bus.in_ready  = !valid || bus.out_ready;
  assign bus.out_valid = valid;
  assign bus.out_data  = data_q;
`ifdef ACC_SAT_EN
  assign bus.out_sat   = sat_q;
`else
  assign bus.out_sat   = 1'b0;
`endif

  // Next state, accumulator update and result capture on the frame's last beat
  always_comb begin
    logic finish;
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    finish  = 1'b0;
`ifdef ACC_SAT_EN
    sat_d   = sat_q;
`endif
    if (clr_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          // In HOLD an accepted beat implies out_ready, so the result pops in the same cycle
          if (accept) begin
            acc_d = bias_x + data_x;
            if (BEATS == 1) begin
              state_d = HOLD;
              cnt_d   = '0;
              finish  = 1'b1;
            end else begin
              state_d = ACC;
              cnt_d   = CW'(1);
            end
          end else if (pop) begin
            state_d = IDLE;
          end
        end
        ACC: begin
          if (accept) begin
            acc_d = acc_q + data_x;
            if (cnt_q == CW'(BEATS - 1)) begin
              state_d = HOLD;
              cnt_d   = '0;
              finish  = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    if (finish) begin
`ifdef ACC_SAT_EN
      if (acc_d > MAX_V) begin
        data_d = {1'b0, {(DWIDTH-1){1'b1}}};
        sat_d  = 1'b1;
      end else if (acc_d < MIN_V) begin
        data_d = {1'b1, {(DWIDTH-1){1'b0}}};
        sat_d  = 1'b1;
      end else begin
        data_d = acc_d[DWIDTH-1:0];
        sat_d  = 1'b0;
      end
`else
      data_d = acc_d[DWIDTH-1:0];
`endif
    end
  end

  // State, counter, accumulator and result registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
`ifdef ACC_SAT_EN
      sat_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
`ifdef ACC_SAT_EN
      sat_q   <= sat_d;
`endif
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// tb/tb_neuron_accumulator.sv - directed scoreboard bench for neuron_accumulator (honours ACC_SAT_EN)
module tb_neuron_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   n_pushed = 0;
  int   n_results = 0;
  logic [16:0] sb[$];
  int   out_cycles[$];

  neuron_accumulator_if #(.DWIDTH(16)) bus ();

  neuron_accumulator #(.DWIDTH(16), .BEATS(4), .GUARD(4)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .clr_i   (clr),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model(input int s);
`ifdef ACC_SAT_EN
    if (s > 32767) return {1'b1, 16'h7FFF};
    if (s < -32768) return {1'b1, 16'h8000};
`endif
    return {1'b0, s[15:0]};
  endfunction

  // Scoreboard: compare every result that leaves the block against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_results++;
      out_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_result", {15'd0, bus.out_sat, bus.out_data}, 32'hFFFFFFFF);
      end else begin
        logic [16:0] e;
        e = sb.pop_front();
        chk("out_data", {16'd0, bus.out_data}, {16'd0, e[15:0]});
        chk("out_sat", {31'd0, bus.out_sat}, {31'd0, e[16]});
      end
    end
  end

  // Present one beat at posedge+1 and hold it until accepted, returning at posedge+1
  task automatic drive_beat(input logic [15:0] d, input logic [15:0] b, input bit check_pop);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_bias  = b;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) chk("in_ready_timeout", 32'd0, 32'd1);
    if (check_pop) chk("pop_with_accept", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [15:0] d2, input logic [15:0] d3,
                            input logic [15:0] b, input bit drop, input bit check_pop);
    int s;
    s = int'($signed(b)) + int'($signed(d0)) + int'($signed(d1)) + int'($signed(d2)) + int'($signed(d3));
    sb.push_back(model(s));
    n_pushed++;
    drive_beat(d0, b, check_pop);
    drive_beat(d1, 16'hDEAD, 1'b0);
    drive_beat(d2, 16'hBEEF, 1'b0);
    drive_beat(d3, 16'h1234, 1'b0);
    if (drop) bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bias   = '0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", {16'd0, bus.out_data}, 32'd0);
    chk("rst_out_sat", {31'd0, bus.out_sat}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    // Basic frame and single-cycle out_valid
    send_frame(16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0010, 1'b1, 1'b0);
    @(negedge clk);
    chk("latency_valid", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    chk("valid_one_cycle", {31'd0, bus.out_valid}, 32'd0);
    idle(1);

    // Positive overflow and negative overflow
    send_frame(16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h0000, 1'b1, 1'b0);
    idle(3);
    send_frame(16'h9000, 16'h9000, 16'h9000, 16'h9000, 16'hF000, 1'b1, 1'b0);
    idle(3);

    // Backpressure: result held stable, then pop and new first beat in the same cycle
    bus.out_ready = 1'b0;
    send_frame(16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0100, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("hold_data", {16'd0, bus.out_data}, 32'h01AA);
      chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    send_frame(16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0000, 1'b1, 1'b1);
    idle(3);

    // Abort with asynchronous reset after two beats
    drive_beat(16'h0100, 16'h0000, 1'b0);
    drive_beat(16'h0100, 16'h0000, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("abort_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_rst_data", {16'd0, bus.out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b0);
    idle(3);

    // Abort with clr after two beats; the beat presented with clr is ignored
    drive_beat(16'h0100, 16'h0000, 1'b0);
    drive_beat(16'h0100, 16'h0000, 1'b0);
    clr = 1'b1;
    bus.in_data = 16'h0500;
    @(posedge clk); #1;
    clr = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("abort_clr_valid", {31'd0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    send_frame(16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000, 1'b1, 1'b0);
    idle(3);

    // Three frames back to back with no bubbles
    out_cycles.delete();
    send_frame(16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0001, 1'b0, 1'b0);
    send_frame(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'h0002, 1'b0, 1'b0);
    send_frame(16'h1000, 16'h2000, 16'h0100, 16'h0200, 16'hFFF0, 1'b1, 1'b0);
    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(2);
    chk("b2b_count", out_cycles.size(), 32'd3);
    if (out_cycles.size() == 3) begin
      chk("b2b_gap1", out_cycles[1] - out_cycles[0], 32'd4);
      chk("b2b_gap2", out_cycles[2] - out_cycles[1], 32'd4);
    end

    chk("sb_empty", sb.size(), 32'd0);
    chk("result_count", n_results, n_pushed);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
